// File: rtl/servo_pkg.sv
// Shared types, default timing and the speed-to-width mapping for the
// servo PWM bank: channel state enum, 100 MHz defaults, saturating map.
package servo_pkg;

    typedef enum logic {
        SERVO_OFF = 1'b0,
        SERVO_RUN = 1'b1
    } servo_state_t;

    localparam int SERVO_PERIOD_DEF = 2_000_000;
    localparam int SERVO_MIN_DEF    = 100_000;
    localparam int SERVO_MID_DEF    = 150_000;
    localparam int SERVO_MAX_DEF    = 200_000;

    // Evaluated at 64 bits, which covers CNT_W+SPEED_W+1 for every
    // legal parameter set, so the product never overflows before the
    // clamp.
    function automatic logic signed [63:0] servo_speed_to_width(
        input logic signed [63:0] speed,
        input logic signed [63:0] mid,
        input logic signed [63:0] step,
        input logic signed [63:0] min_w,
        input logic signed [63:0] max_w
    );
        logic signed [63:0] t;
        t = mid + speed * step;
        if (t < min_w) begin
            t = min_w;
        end else if (t > max_w) begin
            t = max_w;
        end
        return t;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: shadow/active width, OFF/RUN state, optional ramp
// (SERVO_RAMP_EN) and the registered compare that drives the pin.
// Ports: clk, reset_n, load_i (last count of period), cnt_nxt_i (counter
// value for next cycle), wr_en_i/wr_enable_i/wr_width_i (shadow write),
// pwm_o (pulse output), active_o (channel in RUN).
module servo_channel
    import servo_pkg::*;
#(
    parameter int CNT_W     = 21,
    parameter int PULSE_MID = SERVO_MID_DEF
`ifdef SERVO_RAMP_EN
    ,
    parameter int RAMP_STEP = 5_000
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] cnt_nxt_i,
    input  logic             wr_en_i,
    input  logic             wr_enable_i,
    input  logic [CNT_W-1:0] wr_width_i,
    output logic             pwm_o,
    output logic             active_o
);

    localparam logic [CNT_W-1:0] MID_W = CNT_W'(PULSE_MID);

    servo_state_t     state_q, state_d;
    logic             sh_en_q, sh_en_d;
    logic [CNT_W-1:0] sh_w_q, sh_w_d;
    logic [CNT_W-1:0] act_w_q, act_w_d;
    logic             pwm_q, pwm_d;

`ifdef SERVO_RAMP_EN
    localparam logic [CNT_W-1:0] STEP_W = CNT_W'(RAMP_STEP);

    function automatic logic [CNT_W-1:0] ramp_to(
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] tgt
    );
        logic [CNT_W-1:0] r;
        r = tgt;
        if (tgt > cur) begin
            if (tgt - cur > STEP_W) r = cur + STEP_W;
        end else if (cur - tgt > STEP_W) begin
            r = cur - STEP_W;
        end
        return r;
    endfunction
`endif

    always_comb begin
        sh_en_d = sh_en_q;
        sh_w_d  = sh_w_q;
        if (wr_en_i) begin
            sh_en_d = wr_enable_i;
            sh_w_d  = wr_width_i;
        end
    end

    always_comb begin
        state_d = state_q;
        act_w_d = act_w_q;
        if (load_i) begin
            unique case (state_q)
                SERVO_OFF: if (sh_en_q)  state_d = SERVO_RUN;
                SERVO_RUN: if (!sh_en_q) state_d = SERVO_OFF;
                default:                 state_d = SERVO_OFF;
            endcase
`ifdef SERVO_RAMP_EN
            // A channel that was not already running restarts from
            // neutral; only RUN->RUN periods step toward the shadow.
            if (state_q == SERVO_RUN && state_d == SERVO_RUN) begin
                act_w_d = ramp_to(act_w_q, sh_w_q);
            end else begin
                act_w_d = MID_W;
            end
`else
            act_w_d = sh_w_q;
`endif
        end
    end

    // Compare against next-cycle values so the registered pin is high
    // exactly while count_out < width, starting at count 0.
    assign pwm_d = (state_d == SERVO_RUN) && (cnt_nxt_i < act_w_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SERVO_OFF;
            sh_en_q <= 1'b0;
            sh_w_q  <= MID_W;
            act_w_q <= MID_W;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_en_q <= sh_en_d;
            sh_w_q  <= sh_w_d;
            act_w_q <= act_w_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o    = pwm_q;
    assign active_o = (state_q == SERVO_RUN);

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM: shared period counter, command handshake and
// decode, NUM_CH servo_channel instances. Optional ramp: SERVO_RAMP_EN.
// Ports: clk, reset_n, cmd_valid/cmd_ready/cmd_ch/cmd_enable/cmd_speed
// (command in), count_out/period_start (counter out), pwm, ch_active.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 21,
    parameter int PERIOD_CNT = SERVO_PERIOD_DEF,
    parameter int PULSE_MIN  = SERVO_MIN_DEF,
    parameter int PULSE_MID  = SERVO_MID_DEF,
    parameter int PULSE_MAX  = SERVO_MAX_DEF,
    parameter int SPEED_W    = 8,
    parameter int SPEED_STEP = 390,
    parameter int RAMP_STEP  = 5_000
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmd_ch,
    input  logic                                     cmd_enable,
    input  logic signed [SPEED_W-1:0]                cmd_speed,
    output logic [CNT_W-1:0]                         count_out,
    output logic                                     period_start,
    output logic [NUM_CH-1:0]                        pwm,
    output logic [NUM_CH-1:0]                        ch_active
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CNT - 1);

    if (PULSE_MAX >= PERIOD_CNT) begin : g_chk_max
        $error("servo_pwm_bank: PULSE_MAX must be below PERIOD_CNT");
    end
    if (PULSE_MIN > PULSE_MID || PULSE_MID > PULSE_MAX) begin : g_chk_ord
        $error("servo_pwm_bank: need PULSE_MIN <= PULSE_MID <= PULSE_MAX");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_ch
        $error("servo_pwm_bank: NUM_CH must be 1..8");
    end
    if (longint'(PERIOD_CNT) > (longint'(1) << CNT_W)) begin : g_chk_cnt
        $error("servo_pwm_bank: PERIOD_CNT does not fit in CNT_W");
    end
    if (RAMP_STEP < 1) begin : g_chk_ramp
        $error("servo_pwm_bank: RAMP_STEP must be positive");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             started_q, started_d;
    logic             load;
    logic             xfer;
    logic [CNT_W-1:0] cmd_width;

    assign load = (cnt_q == LAST);

    always_comb begin
        cnt_d     = load ? '0 : cnt_q + CNT_W'(1);
        started_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            started_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            started_q <= started_d;
        end
    end

    // Blocked in the first cycle after reset and in the load cycle, so
    // shadow registers never change while a channel samples them.
    assign cmd_ready = started_q & ~load;
    assign xfer      = cmd_valid & cmd_ready;

    assign cmd_width = CNT_W'(servo_speed_to_width(
        64'(cmd_speed),
        64'(PULSE_MID),
        64'(SPEED_STEP),
        64'(PULSE_MIN),
        64'(PULSE_MAX)));

    // Out-of-range cmd_ch matches no channel: accepted and dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_channel #(
            .CNT_W     (CNT_W),
            .PULSE_MID (PULSE_MID)
`ifdef SERVO_RAMP_EN
            ,
            .RAMP_STEP (RAMP_STEP)
`endif
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .load_i      (load),
            .cnt_nxt_i   (cnt_d),
            .wr_en_i     (xfer && (cmd_ch == CH_W'(i))),
            .wr_enable_i (cmd_enable),
            .wr_width_i  (cmd_width),
            .pwm_o       (pwm[i]),
            .active_o    (ch_active[i])
        );
    end

    assign count_out    = cnt_q;
    assign period_start = (cnt_q == '0);

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank with a small period (100 clocks);
// a monitor measures each period's pulses against a scoreboard queue.
module tb_servo_pwm_bank;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 8;
    localparam int PERIOD  = 100;
    localparam int PMIN    = 10;
    localparam int PMID    = 15;
    localparam int PMAX    = 20;
    localparam int SPEED_W = 4;
    localparam int SSTEP   = 1;
    localparam int RSTEP   = 2;
`ifdef SERVO_RAMP_EN
    localparam bit RAMP   = 1'b1;
    localparam int EN_W   = 15;
    localparam int SAT_HI = 17;
    localparam int CH1_W  = 15;
    localparam int SAT_LO = 17;
    localparam int DIS_W  = 12;
`else
    localparam bit RAMP   = 1'b0;
    localparam int EN_W   = 18;
    localparam int SAT_HI = 20;
    localparam int CH1_W  = 13;
    localparam int SAT_LO = 10;
    localparam int DIS_W  = 18;
`endif

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      cmd_valid = 1'b0;
    logic                      cmd_ready;
    logic [0:0]                cmd_ch = '0;
    logic                      cmd_enable = 1'b0;
    logic signed [SPEED_W-1:0] cmd_speed = '0;
    logic [CNT_W-1:0]          count_out;
    logic                      period_start;
    logic [NUM_CH-1:0]         pwm;
    logic [NUM_CH-1:0]         ch_active;

    servo_pwm_bank #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .PERIOD_CNT (PERIOD),
        .PULSE_MIN  (PMIN),
        .PULSE_MID  (PMID),
        .PULSE_MAX  (PMAX),
        .SPEED_W    (SPEED_W),
        .SPEED_STEP (SSTEP),
        .RAMP_STEP  (RSTEP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ch       (cmd_ch),
        .cmd_enable   (cmd_enable),
        .cmd_speed    (cmd_speed),
        .count_out    (count_out),
        .period_start (period_start),
        .pwm          (pwm),
        .ch_active    (ch_active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         w0;
        int         w1;
        logic [1:0] act;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    bit   m_run[2];
    int   m_w[2];
    bit   m_sh_en[2];
    int   m_sh_w[2];
    int   hi[2];
    bit   glitch[2];
    int   last_w[2];
    int   acc;

    function automatic int map_speed(input int s);
        int t;
        t = PMID + s * SSTEP;
        if (t < PMIN) t = PMIN;
        if (t > PMAX) t = PMAX;
        return t;
    endfunction

    function automatic int step_to(input int cur, input int tgt);
        if (tgt > cur + RSTEP) return cur + RSTEP;
        if (tgt < cur - RSTEP) return cur - RSTEP;
        return tgt;
    endfunction

    task automatic model_load();
        for (int i = 0; i < 2; i++) begin
            if (!m_run[i]) begin
                if (m_sh_en[i]) begin
                    m_run[i] = 1'b1;
                    m_w[i]   = RAMP ? PMID : m_sh_w[i];
                end
            end else if (!m_sh_en[i]) begin
                m_run[i] = 1'b0;
            end else begin
                m_w[i] = RAMP ? step_to(m_w[i], m_sh_w[i]) : m_sh_w[i];
            end
        end
    endtask

    // Period monitor: measures each channel's pulse over a full period,
    // pops the expectation for that period, then pushes the next one.
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i]   = 1'b0;
                m_w[i]     = PMID;
                m_sh_en[i] = 1'b0;
                m_sh_w[i]  = PMID;
                hi[i]      = 0;
                glitch[i]  = 1'b0;
            end
            sbq.delete();
            sbq.push_back('{0, 0, 2'b00});
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pwm[i]) begin
                    if (hi[i] != int'(count_out)) glitch[i] = 1'b1;
                    hi[i]++;
                end
            end
            if (int'(count_out) == PERIOD - 1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: no expectation at period end");
                end else begin
                    mon_e = sbq.pop_front();
                    checks++;
                    if (hi[0] !== mon_e.w0 || glitch[0]) begin
                        errors++;
                        $display("FAIL sb_w0: got %0d split=%0d want %0d",
                                 hi[0], glitch[0], mon_e.w0);
                    end
                    checks++;
                    if (hi[1] !== mon_e.w1 || glitch[1]) begin
                        errors++;
                        $display("FAIL sb_w1: got %0d split=%0d want %0d",
                                 hi[1], glitch[1], mon_e.w1);
                    end
                    checks++;
                    if (ch_active !== mon_e.act) begin
                        errors++;
                        $display("FAIL sb_act: got %b want %b",
                                 ch_active, mon_e.act);
                    end
                end
                last_w[0] = hi[0];
                last_w[1] = hi[1];
                model_load();
                sbq.push_back('{m_run[0] ? m_w[0] : 0,
                                m_run[1] ? m_w[1] : 0,
                                {m_run[1], m_run[0]}});
                for (int i = 0; i < 2; i++) begin
                    hi[i]     = 0;
                    glitch[i] = 1'b0;
                end
            end
        end
    end

    task automatic wait_count(input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(count_out) != c && n < 3 * PERIOD);
        if (int'(count_out) != c) begin
            checks++;
            errors++;
            $display("FAIL wait_count: got %0d want %0d", count_out, c);
        end
    endtask

    task automatic end_period();
        wait_count(PERIOD - 1);
        @(negedge clk);
    endtask

    task automatic send(input int ch, input bit en, input int spd,
                        output int acc_cnt);
        int n;
        n          = 0;
        acc_cnt    = -1;
        cmd_ch     = 1'(ch);
        cmd_enable = en;
        cmd_speed  = SPEED_W'(spd);
        cmd_valid  = 1'b1;
        while (!cmd_ready && n < 3 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready) begin
            acc_cnt = int'(count_out);
            if (ch < NUM_CH) begin
                m_sh_en[ch] = en;
                m_sh_w[ch]  = map_speed(spd);
            end
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end else begin
            cmd_valid = 1'b0;
            checks++;
            errors++;
            $display("FAIL send_timeout: ready=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (count_out !== '0 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL rst_cnt: got %0d/%b want 0/1",
                     count_out, period_start);
        end
        checks++;
        if (pwm !== 2'b00 || ch_active !== 2'b00) begin
            errors++;
            $display("FAIL rst_out: got %b/%b want 00/00", pwm, ch_active);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: got %b want 0", cmd_ready);
        end
        #2 reset_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_ready: got %b want 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || count_out !== CNT_W'(1)) begin
            errors++;
            $display("FAIL run_ready: got %b/%0d want 1/1",
                     cmd_ready, count_out);
        end
    endtask

    task automatic test_enable();
        wait_count(2);
        send(0, 1'b1, 3, acc);
        wait_count(0);
        checks++;
        if (pwm !== 2'b01 || ch_active !== 2'b01) begin
            errors++;
            $display("FAIL en_start: got %b/%b want 01/01", pwm, ch_active);
        end
        wait_count(EN_W - 1);
        checks++;
        if (pwm[0] !== 1'b1) begin
            errors++;
            $display("FAIL en_last: got %b want 1", pwm[0]);
        end
        wait_count(EN_W);
        checks++;
        if (pwm !== 2'b00) begin
            errors++;
            $display("FAIL en_end: got %b want 00", pwm);
        end
    endtask

    task automatic test_saturation();
        send(0, 1'b1, 7, acc);
        send(1, 1'b1, -2, acc);
        end_period();
        end_period();
        checks++;
        if (last_w[0] !== SAT_HI) begin
            errors++;
            $display("FAIL sat_hi: got %0d want %0d", last_w[0], SAT_HI);
        end
        checks++;
        if (last_w[1] !== CH1_W || ch_active !== 2'b11) begin
            errors++;
            $display("FAIL ch1_w: got %0d/%b want %0d/11",
                     last_w[1], ch_active, CH1_W);
        end
        send(0, 1'b1, 0, acc);
        send(0, 1'b1, -8, acc);
        end_period();
        end_period();
        checks++;
        if (last_w[0] !== SAT_LO) begin
            errors++;
            $display("FAIL sat_lo: got %0d want %0d", last_w[0], SAT_LO);
        end
    endtask

    task automatic test_boundary();
        wait_count(PERIOD - 1);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready: got %b want 0", cmd_ready);
        end
        send(1, 1'b1, 4, acc);
        checks++;
        if (acc !== 0) begin
            errors++;
            $display("FAIL acc_cnt: got %0d want 0", acc);
        end
        wait_count(12);
        checks++;
        if (pwm[1] !== 1'b1) begin
            errors++;
            $display("FAIL old_w_hi: got %b want 1", pwm[1]);
        end
        wait_count(13);
        checks++;
        if (pwm[1] !== 1'b0) begin
            errors++;
            $display("FAIL old_w_lo: got %b want 0", pwm[1]);
        end
        end_period();
        wait_count(13);
        checks++;
        if (pwm[1] !== 1'b1) begin
            errors++;
            $display("FAIL new_w: got %b want 1", pwm[1]);
        end
        wait_count(PERIOD - 2);
        send(1, 1'b1, 2, acc);
        checks++;
        if (acc !== PERIOD - 2) begin
            errors++;
            $display("FAIL late_acc: got %0d want %0d", acc, PERIOD - 2);
        end
        wait_count(16);
        checks++;
        if (pwm[1] !== 1'b1) begin
            errors++;
            $display("FAIL late_hi: got %b want 1", pwm[1]);
        end
        wait_count(17);
        checks++;
        if (pwm[1] !== 1'b0) begin
            errors++;
            $display("FAIL late_lo: got %b want 0", pwm[1]);
        end
    endtask

    task automatic test_disable();
        send(0, 1'b1, 3, acc);
        wait_count(5);
        checks++;
        if (ch_active[0] !== 1'b1) begin
            errors++;
            $display("FAIL dis_pre: got %b want 1", ch_active[0]);
        end
        send(0, 1'b0, 0, acc);
        end_period();
        checks++;
        if (last_w[0] !== DIS_W) begin
            errors++;
            $display("FAIL dis_w: got %0d want %0d", last_w[0], DIS_W);
        end
        checks++;
        if (ch_active[0] !== 1'b0 || pwm[0] !== 1'b0) begin
            errors++;
            $display("FAIL dis_off: got %b/%b want 0/0",
                     ch_active[0], pwm[0]);
        end
    endtask

    task automatic test_reset_mid();
        wait_count(8);
        checks++;
        if (pwm[1] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got %b want 1", pwm[1]);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (pwm !== 2'b00 || count_out !== '0) begin
            errors++;
            $display("FAIL mid_rst: got %b/%0d want 00/0", pwm, count_out);
        end
        checks++;
        if (ch_active !== 2'b00 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_flags: got %b/%b want 00/0",
                     ch_active, cmd_ready);
        end
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        end_period();
        checks++;
        if (last_w[0] !== 0 || last_w[1] !== 0 || ch_active !== 2'b00) begin
            errors++;
            $display("FAIL post_rst: got %0d/%0d/%b want 0/0/00",
                     last_w[0], last_w[1], ch_active);
        end
    endtask

    task automatic test_ramp();
        int tbl[4];
`ifdef SERVO_RAMP_EN
        tbl = '{15, 17, 19, 20};
`else
        tbl = '{20, 20, 20, 20};
`endif
        send(0, 1'b1, 5, acc);
        end_period();
        for (int k = 0; k < 4; k++) begin
            end_period();
            checks++;
            if (last_w[0] !== tbl[k]) begin
                errors++;
                $display("FAIL ramp_%0d: got %0d want %0d",
                         k, last_w[0], tbl[k]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_enable();
        test_saturation();
        test_boundary();
        test_disable();
        test_reset_mid();
        test_ramp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
